mac_operand_sequencer: RTL and testbench

- Initiator side of the digital MAC interface: it drives `data_in`/`weight_in`/`enable`/`reset` into the MAC and captures `data_out`.
- On a start command it clears the MAC accumulator, then streams `len` activation/weight pairs from two synchronous-read operand buffers, one pair per cycle.
- After the stream it waits for the MAC pipeline to drain, captures the accumulated result and presents it on a valid/ready output.
- Sits between the CNN layer controller and one digital MAC instance.

---
 rtl/mac_seq_pkg.sv | 9 +
 rtl/mac_seq_addr_gen.sv | 28 ++
 rtl/mac_operand_sequencer.sv | 122 ++++++++++++
 tb/tb_mac_operand_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and default sizes for the MAC operand sequencer.
package mac_seq_pkg;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ACC_W       = 17;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_MAC_LATENCY = 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/mac_seq_addr_gen.sv
// Term counter and operand address generation for the ISSUE phase.
module mac_seq_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] act_base,
  input  logic [ADDR_W-1:0] wgt_base,
  output logic [ADDR_W-1:0] act_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              last
);
  logic [ADDR_W-1:0] cnt_q;

  // Counter runs only while issuing, so every burst starts at term 0.
  always_ff @(posedge clock) begin
    if (reset)      cnt_q <= '0;
    else if (issue) cnt_q <= cnt_q + ADDR_W'(1);
    else            cnt_q <= '0;
  end

  // Addresses wrap modulo 2^ADDR_W through natural adder overflow.
  assign act_addr = issue ? act_base + cnt_q : '0;
  assign wgt_addr = issue ? wgt_base + cnt_q : '0;
  assign last     = issue && (cnt_q == len - ADDR_W'(1));
endmodule

// File: rtl/mac_operand_sequencer.sv
// Streams activation/weight pairs into one MAC and returns the accumulated result.
// Define MAC_SEQ_RELU_EN to clamp negative results to zero on capture.
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int MAC_LATENCY = DEF_MAC_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] act_base,
  input  logic [ADDR_W-1:0] wgt_base,
  output logic              busy,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_addr,
  input  logic [DATA_W-1:0] act_rdata,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_addr,
  input  logic [DATA_W-1:0] wgt_rdata,
  output logic              mac_clear,
  output logic              mac_enable,
  output logic [DATA_W-1:0] mac_data,
  output logic [DATA_W-1:0] mac_weight,
  input  logic [ACC_W-1:0]  mac_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
);
  localparam int DRAIN_W = $clog2(MAC_LATENCY + 2);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  len_q, act_base_q, wgt_base_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               drain_done, last;
  logic [ACC_W-1:0]   cap_val;

  assign mac_data   = act_rdata;
  assign mac_weight = wgt_rdata;
  assign drain_done = (state_q == DRAIN) && (drain_q == DRAIN_W'(MAC_LATENCY));

`ifdef MAC_SEQ_RELU_EN
  assign cap_val = mac_result[ACC_W-1] ? '0 : mac_result;
`else
  assign cap_val = mac_result;
`endif

  mac_seq_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clock    (clock),
    .reset    (reset),
    .issue    (act_rd_en),
    .len      (len_q),
    .act_base (act_base_q),
    .wgt_base (wgt_base_q),
    .act_addr (act_addr),
    .wgt_addr (wgt_addr),
    .last     (last)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : CLEAR;
      CLEAR:   state_d = ISSUE;
      ISSUE:   if (last) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = DONE;
      DONE:    if (res_valid && res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mac_clear = (state_q == CLEAR);
    act_rd_en = (state_q == ISSUE);
    wgt_rd_en = (state_q == ISSUE);
  end

  // Command latch, enable pipeline (aligns with 1-cycle buffer read) and drain timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_q      <= '0;
      act_base_q <= '0;
      wgt_base_q <= '0;
      mac_enable <= 1'b0;
      drain_q    <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        len_q      <= len;
        act_base_q <= act_base;
        wgt_base_q <= wgt_base;
      end
      mac_enable <= act_rd_en;
      drain_q    <= (state_q == DRAIN) ? drain_q + DRAIN_W'(1) : '0;
    end
  end

  // A zero-length command enters DONE without a valid result; it is raised a cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (state_q == IDLE && start && len == '0) res_data <= '0;
      if (drain_done) begin
        res_valid <= 1'b1;
        res_data  <= cap_val;
      end else if (state_q == DONE) begin
        if (res_valid && res_ready) res_valid <= 1'b0;
        else                        res_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed + randomized checks of mac_operand_sequencer against a dot-product reference.
module tb_mac_operand_sequencer;
  logic        clock = 1'b0;
  logic        reset, start, res_ready;
  logic [7:0]  len, act_base, wgt_base;
  logic        busy, act_rd_en, wgt_rd_en, mac_clear, mac_enable, res_valid;
  logic [7:0]  act_addr, wgt_addr;
  logic [15:0] act_rdata, wgt_rdata, mac_data, mac_weight;
  logic [16:0] mac_result, res_data;

  logic [15:0] act_mem [256];
  logic [15:0] wgt_mem [256];
  logic [16:0] acc;
  int errors = 0, checks = 0;
  int clr_cnt = 0, en_cnt = 0, ovl_cnt = 0;
  int clr0, en0, q0;
  logic [7:0] aq[$], wq[$];

  always #5 clock = ~clock;

  mac_operand_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .len(len),
    .act_base(act_base), .wgt_base(wgt_base), .busy(busy),
    .act_rd_en(act_rd_en), .act_addr(act_addr), .act_rdata(act_rdata),
    .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
    .mac_clear(mac_clear), .mac_enable(mac_enable), .mac_data(mac_data),
    .mac_weight(mac_weight), .mac_result(mac_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data)
  );

  // Environment: synchronous-read buffers and a behavioural 1-cycle MAC.
  always @(posedge clock) begin
    if (act_rd_en) act_rdata <= act_mem[act_addr];
    if (wgt_rd_en) wgt_rdata <= wgt_mem[wgt_addr];
    if (mac_clear)       acc <= '0;
    else if (mac_enable) acc <= acc + 17'($signed(mac_data) * $signed(mac_weight));
  end
  assign mac_result = acc;

  always @(negedge clock) begin
    if (mac_clear) clr_cnt++;
    if (mac_enable) en_cnt++;
    if (mac_clear && mac_enable) ovl_cnt++;
    if (act_rd_en) aq.push_back(act_addr);
    if (wgt_rd_en) wq.push_back(wgt_addr);
  end

  function automatic logic [16:0] ref_dot(input int l, input int ab, input int wb);
    longint s = 0;
    logic [16:0] r;
    for (int i = 0; i < l; i++)
      s += longint'($signed(act_mem[(ab + i) % 256])) * longint'($signed(wgt_mem[(wb + i) % 256]));
    r = s[16:0];
`ifdef MAC_SEQ_RELU_EN
    if (r[16]) r = '0;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input int l, input int ab, input int wb);
    @(negedge clock);
    start = 1'b1; len = 8'(l); act_base = 8'(ab); wgt_base = 8'(wb);
    clr0 = clr_cnt; en0 = en_cnt; q0 = aq.size();
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Counts edges from the start-sampling edge (inclusive) to res_valid.
  task automatic wait_valid(output int n);
    n = 1;
    while (!res_valid && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic check_run(input string tag, input int l, input int ab, input int wb, input int n);
    int bad = 0;
    chk({tag, " latency"}, n, (l == 0) ? 2 : l + 4);
    chk({tag, " res_data"}, res_data, ref_dot(l, ab, wb));
    chk({tag, " clear pulses"}, clr_cnt - clr0, (l == 0) ? 0 : 1);
    chk({tag, " enable pulses"}, en_cnt - en0, l);
    for (int i = 0; i < l; i++) begin
      if (q0 + i >= aq.size() || q0 + i >= wq.size()) bad++;
      else if (aq[q0 + i] !== 8'((ab + i) % 256) || wq[q0 + i] !== 8'((wb + i) % 256)) bad++;
    end
    chk({tag, " addr errors"}, bad, 0);
    chk({tag, " rd count"}, aq.size() - q0, l);
  endtask

  task automatic finish_handshake(input string tag);
    res_ready = 1'b1;
    @(posedge clock); #1;
    chk({tag, " valid drop"}, res_valid, 0);
    chk({tag, " busy drop"}, busy, 0);
  endtask

  initial begin
    int n;
    logic [16:0] held;
    for (int i = 0; i < 256; i++) begin
      act_mem[i] = 16'($urandom);
      wgt_mem[i] = 16'($urandom);
    end
    for (int i = 0; i < 4; i++) act_mem[i] = 16'd1;
    wgt_mem[0] = 16'd1; wgt_mem[1] = 16'd2; wgt_mem[2] = 16'hFFFF; wgt_mem[3] = 16'd127;
    act_mem[10] = 16'd1; wgt_mem[10] = 16'd24;
    act_mem[20] = 16'd1; wgt_mem[20] = 16'hFFFB;
    acc = '0; act_rdata = '0; wgt_rdata = '0;
    reset = 1'b1; start = 1'b0; res_ready = 1'b1; len = '0; act_base = '0; wgt_base = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    chk("idle outputs", {busy, act_rd_en, wgt_rd_en, mac_clear, mac_enable, res_valid, act_addr, wgt_addr}, 0);
    chk("idle res_data", res_data, 0);

    launch(0, 5, 5); wait_valid(n);
    check_run("len0", 0, 5, 5, n);
    finish_handshake("len0");

    launch(3, 0, 0); wait_valid(n);
    check_run("dot3", 3, 0, 0, n);
    chk("dot3 value", res_data, 2);
    finish_handshake("dot3");

    res_ready = 1'b0;
    launch(4, 0, 0); wait_valid(n);
    check_run("dot4", 4, 0, 0, n);
    chk("dot4 value", res_data, 129);
    held = res_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); start = (k == 2); len = 8'd1;
      @(posedge clock); #1;
      start = 1'b0;
      chk("bp valid held", res_valid, 1);
      chk("bp data held", res_data, held);
    end
    @(negedge clock); res_ready = 1'b1; start = 1'b1; len = 8'd3;
    @(posedge clock); #1;
    start = 1'b0;
    chk("bp handshake valid", res_valid, 0);
    chk("bp handshake busy", busy, 0);
    @(posedge clock); #1;
    chk("start ignored busy", busy, 0);
    chk("start ignored clear", clr_cnt - clr0, 1);

    launch(1, 10, 10); wait_valid(n);
    check_run("reacc", 1, 10, 10, n);
    chk("reacc value", res_data, 24);
    finish_handshake("reacc");

    launch(4, 254, 254); wait_valid(n);
    check_run("wrap", 4, 254, 254, n);
    finish_handshake("wrap");

    launch(10, 30, 60);
    repeat (5) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst outputs", {busy, act_rd_en, wgt_rd_en, mac_clear, mac_enable, res_valid, act_addr, wgt_addr}, 0);
    chk("midrst res_data", res_data, 0);
    reset = 1'b0;
    n = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (res_valid || busy) n++;
    end
    chk("midrst quiet", n, 0);
    launch(2, 40, 80); wait_valid(n);
    check_run("post rst", 2, 40, 80, n);
    finish_handshake("post rst");

    launch(1, 20, 20); wait_valid(n);
    check_run("relu", 1, 20, 20, n);
`ifdef MAC_SEQ_RELU_EN
    chk("relu value", res_data, 0);
`else
    chk("relu value", res_data, 17'h1FFFB);
`endif
    finish_handshake("relu");

    for (int r = 0; r < 6; r++) begin
      int l, ab, wb;
      l = $urandom_range(1, 24); ab = $urandom_range(0, 255); wb = $urandom_range(0, 255);
      launch(l, ab, wb); wait_valid(n);
      check_run("rand", l, ab, wb, n);
      finish_handshake("rand");
    end

    chk("clear/enable overlap", ovl_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
